// File: rtl/stream_mat_vec_mul.sv
// Streaming y = H*x (+ y0) engine over GF(256) or F251.
// H streams in column-major, x comes from a 1-cycle memory.
module stream_mat_vec_mul #(
    parameter string FIELD = "GF256",
    parameter int N_GF = 4,
    parameter int ROWS = 104,
    parameter int COLS = 126,
    localparam int PROC_SIZE = 8 * N_GF,
    localparam int WPC = (ROWS + N_GF - 1) / N_GF,
    localparam int AW = (COLS > 1) ? $clog2(COLS) : 1,
    localparam int RW = (WPC > 1) ? $clog2(WPC) : 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_start,
    input  logic                 i_add_mode,
    input  logic [PROC_SIZE-1:0] i_mat_data,
    input  logic                 i_mat_valid,
    output logic                 o_mat_ready,
    output logic [AW-1:0]        o_vec_addr,
    input  logic [7:0]           i_vec,
    input  logic                 i_res_en,
    input  logic                 i_res_wen,
    input  logic [RW-1:0]        i_res_addr,
    input  logic [PROC_SIZE-1:0] i_res_data,
    output logic [PROC_SIZE-1:0] o_res,
    output logic                 o_busy,
    output logic                 o_done
);

    localparam bit IS_P251 = (FIELD == "P251");

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_ADDR,
        S_XCAP,
        S_MAC,
        S_DONE
    } state_t;

    state_t               state;
    logic [RW-1:0]        w_cnt;
    logic [7:0]           x_reg;
    logic                 add_mode;
    logic [PROC_SIZE-1:0] acc [WPC];
    logic [PROC_SIZE-1:0] mac_word;
    logic                 res_addr_ok;
    logic                 mat_fire;

    // GF(2^8) multiply, shift-and-add with x^8+x^4+x^3+x+1 folding.
    function automatic logic [7:0] gf_mul(
        input logic [7:0] a,
        input logic [7:0] b
    );
        logic [7:0] p;
        logic [7:0] t;
        p = '0;
        t = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ t;
            t = t[7] ? ({t[6:0], 1'b0} ^ 8'h1B) : {t[6:0], 1'b0};
        end
        return p;
    endfunction

    // One lane of acc + mat * x in the selected field.
    function automatic logic [7:0] lane_mac(
        input logic [7:0] a,
        input logic [7:0] b,
        input logic [7:0] c
    );
        logic [16:0] s;
        if (IS_P251) begin
            s = 17'(a) * 17'(b) + 17'(c);
            return 8'(s % 17'd251);
        end else begin
            return c ^ gf_mul(a, b);
        end
    endfunction

    assign res_addr_ok = (32'(i_res_addr) < WPC);
    assign mat_fire = i_mat_valid & o_mat_ready;

    // Updated accumulator word; padding lanes past ROWS keep their value.
    always_comb begin
        mac_word = acc[w_cnt];
        for (int k = 0; k < N_GF; k++) begin
            if (int'(w_cnt) * N_GF + k < ROWS) begin
                mac_word[8*k +: 8] = lane_mac(i_mat_data[8*k +: 8],
                                              x_reg,
                                              acc[w_cnt][8*k +: 8]);
            end
        end
    end

    // Control FSM, column/word counters, accumulator bank and host port.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= S_IDLE;
            w_cnt       <= '0;
            x_reg       <= '0;
            add_mode    <= 1'b0;
            o_mat_ready <= 1'b0;
            o_vec_addr  <= '0;
            o_res       <= '0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            for (int i = 0; i < WPC; i++) acc[i] <= '0;
        end else begin
            o_done <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (i_res_en && res_addr_ok) o_res <= acc[i_res_addr];
                    if (i_res_wen && res_addr_ok) acc[i_res_addr] <= i_res_data;
                    if (i_start) begin
                        add_mode <= i_add_mode;
                        o_busy   <= 1'b1;
                        state    <= S_INIT;
                    end
                end
                S_INIT: begin
                    if (!add_mode) begin
                        for (int i = 0; i < WPC; i++) acc[i] <= '0;
                    end
                    o_vec_addr <= '0;
                    w_cnt      <= '0;
                    state      <= S_ADDR;
                end
                S_ADDR: begin
                    state <= S_XCAP;
                end
                S_XCAP: begin
                    x_reg       <= i_vec;
                    o_mat_ready <= 1'b1;
                    state       <= S_MAC;
                end
                S_MAC: begin
                    if (mat_fire) begin
                        if (x_reg != 8'd0) acc[w_cnt] <= mac_word;
                        if (w_cnt == RW'(WPC - 1)) begin
                            w_cnt       <= '0;
                            o_mat_ready <= 1'b0;
                            if (o_vec_addr == AW'(COLS - 1)) begin
                                state <= S_DONE;
                            end else begin
                                o_vec_addr <= o_vec_addr + 1'b1;
                                state      <= S_ADDR;
                            end
                        end else begin
                            w_cnt <= w_cnt + 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    o_done <= 1'b1;
                    o_busy <= 1'b0;
                    state  <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stream_mat_vec_mul.sv
// Bench for stream_mat_vec_mul: GF256 and P251 instances,
// scoreboard on host reads against a row/column field model.
module tb_stream_mat_vec_mul;

    localparam int N    = 4;
    localparam int ROWS = 5;
    localparam int COLS = 3;
    localparam int WPC  = 2;
    localparam int NW   = COLS * WPC;
    localparam int LAT  = 1 + COLS * (2 + WPC) + 1;

    logic        clk;
    logic        rst_n;
    logic        start [2];
    logic        add_m [2];
    logic [31:0] mat_data [2];
    logic        mat_valid [2];
    logic        mat_ready [2];
    logic [1:0]  vec_addr [2];
    logic [7:0]  vec [2];
    logic        res_en [2];
    logic        res_wen [2];
    logic [0:0]  res_addr [2];
    logic [31:0] res_data [2];
    logic [31:0] res [2];
    logic        busy [2];
    logic        done [2];

    logic [7:0]  xmem [2][4];
    logic [7:0]  hmat [2][COLS][WPC*N];
    logic [7:0]  macc [2][WPC*N];
    logic [31:0] exp_q0 [$];
    logic [31:0] exp_q1 [$];
    logic        rd_v [2];
    int          n_chk;
    int          n_fail;

    stream_mat_vec_mul #(
        .FIELD("GF256"), .N_GF(N), .ROWS(ROWS), .COLS(COLS)
    ) u_gf (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_start(start[0]), .i_add_mode(add_m[0]),
        .i_mat_data(mat_data[0]), .i_mat_valid(mat_valid[0]),
        .o_mat_ready(mat_ready[0]),
        .o_vec_addr(vec_addr[0]), .i_vec(vec[0]),
        .i_res_en(res_en[0]), .i_res_wen(res_wen[0]),
        .i_res_addr(res_addr[0]), .i_res_data(res_data[0]),
        .o_res(res[0]), .o_busy(busy[0]), .o_done(done[0])
    );

    stream_mat_vec_mul #(
        .FIELD("P251"), .N_GF(N), .ROWS(ROWS), .COLS(COLS)
    ) u_p (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_start(start[1]), .i_add_mode(add_m[1]),
        .i_mat_data(mat_data[1]), .i_mat_valid(mat_valid[1]),
        .o_mat_ready(mat_ready[1]),
        .o_vec_addr(vec_addr[1]), .i_vec(vec[1]),
        .i_res_en(res_en[1]), .i_res_wen(res_wen[1]),
        .i_res_addr(res_addr[1]), .i_res_data(res_data[1]),
        .o_res(res[1]), .o_busy(busy[1]), .o_done(done[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // x memory with one cycle of read latency
    always @(posedge clk) begin
        vec[0] <= xmem[0][vec_addr[0]];
        vec[1] <= xmem[1][vec_addr[1]];
    end

    // read issued this edge -> o_res valid until next edge
    always @(posedge clk) begin
        rd_v[0] <= res_en[0];
        rd_v[1] <= res_en[1];
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic mon_check(input int f);
        logic [31:0] e;
        if (f == 0) begin
            if (exp_q0.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL sb_empty gf: got read, expected none");
                return;
            end
            e = exp_q0.pop_front();
            chk("res_gf", res[0], e);
        end else begin
            if (exp_q1.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL sb_empty p251: got read, expected none");
                return;
            end
            e = exp_q1.pop_front();
            chk("res_p251", res[1], e);
        end
    endtask

    // monitor: compare every host read against the scoreboard
    always @(negedge clk) begin
        if (rst_n && rd_v[0]) mon_check(0);
        if (rst_n && rd_v[1]) mon_check(1);
    end

    function automatic logic [7:0] gf_ref(input logic [7:0] a,
                                          input logic [7:0] b);
        logic [14:0] p;
        p = '0;
        for (int i = 0; i < 8; i++)
            if (b[i]) p = p ^ (15'(a) << i);
        for (int i = 14; i >= 8; i--)
            if (p[i]) p = p ^ (15'h11B << (i - 8));
        return p[7:0];
    endfunction

    function automatic logic [7:0] lane_ref(input int f, input logic [7:0] h,
                                            input logic [7:0] x,
                                            input logic [7:0] y);
        if (x == 8'd0) return y;
        if (f == 0) return y ^ gf_ref(h, x);
        return 8'((int'(h) * int'(x) + int'(y)) % 251);
    endfunction

    function automatic logic [31:0] exp_word(input int f, input int w);
        return {macc[f][w*N+3], macc[f][w*N+2], macc[f][w*N+1], macc[f][w*N]};
    endfunction

    function automatic logic [31:0] stream_word(input int f, input int idx);
        int c;
        int w;
        c = idx / WPC;
        w = idx % WPC;
        return {hmat[f][c][w*N+3], hmat[f][c][w*N+2],
                hmat[f][c][w*N+1], hmat[f][c][w*N]};
    endfunction

    task automatic push_exp(input int f, input logic [31:0] v);
        if (f == 0) exp_q0.push_back(v);
        else exp_q1.push_back(v);
    endtask

    task automatic model_run(input int f, input logic am);
        if (!am)
            for (int r = 0; r < WPC * N; r++) macc[f][r] = 8'd0;
        for (int c = 0; c < COLS; c++)
            for (int r = 0; r < ROWS; r++)
                macc[f][r] = lane_ref(f, hmat[f][c][r], xmem[f][c], macc[f][r]);
    endtask

    task automatic host_write(input int f, input int w,
                              input logic [31:0] d, input logic rd);
        @(negedge clk);
        res_wen[f]  = 1'b1;
        res_en[f]   = rd;
        res_addr[f] = 1'(w);
        res_data[f] = d;
        if (rd) push_exp(f, exp_word(f, w));
        for (int k = 0; k < N; k++) macc[f][w*N+k] = d[8*k +: 8];
        @(negedge clk);
        res_wen[f] = 1'b0;
        res_en[f]  = 1'b0;
    endtask

    task automatic read_word(input int f, input int w, input logic [31:0] e);
        @(negedge clk);
        res_en[f]   = 1'b1;
        res_addr[f] = 1'(w);
        push_exp(f, e);
        @(negedge clk);
        res_en[f] = 1'b0;
    endtask

    task automatic read_all(input int f);
        for (int w = 0; w < WPC; w++) read_word(f, w, exp_word(f, w));
    endtask

    task automatic rand_mat(input int f, input bit xzero);
        for (int c = 0; c < COLS; c++) begin
            for (int r = 0; r < WPC * N; r++) hmat[f][c][r] = 8'($urandom);
            xmem[f][c] = 8'($urandom);
            if (xzero && ($urandom_range(0, 3) == 0)) xmem[f][c] = 8'd0;
        end
    endtask

    task automatic run(input int f, input logic am, input bit stall,
                       input bit inject, input int abort_at);
        int cyc;
        int idx;
        int stalls;
        @(negedge clk);
        start[f] = 1'b1;
        add_m[f] = am;
        @(negedge clk);
        start[f] = 1'b0;
        cyc = 0;
        idx = 0;
        stalls = 0;
        while (!done[f] && cyc < 400) begin
            mat_valid[f] = (idx < NW) && !(stall && (cyc % 2 == 1));
            mat_data[f] = (idx < NW) ? stream_word(f, idx) : $urandom;
            if (mat_ready[f] && (idx < NW) && !mat_valid[f]) stalls++;
            if (mat_ready[f] && mat_valid[f]) idx++;
            start[f] = inject && (cyc == 5);
            res_wen[f] = inject && (cyc == 7);
            res_addr[f] = 1'b0;
            res_data[f] = 32'hFFFF_FFFF;
            if (cyc == abort_at) begin
                mat_valid[f] = 1'b0;
                rst_n = 1'b0;
                #1;
                chk("rst_mat_ready", 32'(mat_ready[f]), 32'd0);
                chk("rst_busy", 32'(busy[f]), 32'd0);
                chk("rst_done", 32'(done[f]), 32'd0);
                chk("rst_res", res[f], 32'd0);
                chk("rst_vec_addr", 32'(vec_addr[f]), 32'd0);
                @(negedge clk);
                rst_n = 1'b1;
                for (int g = 0; g < 2; g++)
                    for (int r = 0; r < WPC * N; r++) macc[g][r] = 8'd0;
                start[f] = 1'b0;
                res_wen[f] = 1'b0;
                return;
            end
            @(negedge clk);
            cyc++;
        end
        mat_valid[f] = 1'b0;
        start[f] = 1'b0;
        res_wen[f] = 1'b0;
        if (!done[f]) begin
            n_chk++; n_fail++;
            $display("FAIL done_timeout: got no o_done in %0d cycles, expected %0d",
                     cyc, LAT + stalls);
        end else begin
            chk("latency", 32'(cyc), 32'(LAT + stalls));
            chk("busy_after_done", 32'(busy[f]), 32'd0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no end of test, expected finish");
        $fatal(1);
    end

    initial begin
        n_chk = 0;
        n_fail = 0;
        rst_n = 1'b0;
        for (int f = 0; f < 2; f++) begin
            start[f] = 1'b0; add_m[f] = 1'b0;
            mat_data[f] = '0; mat_valid[f] = 1'b0;
            res_en[f] = 1'b0; res_wen[f] = 1'b0;
            res_addr[f] = '0; res_data[f] = '0;
            for (int r = 0; r < WPC * N; r++) macc[f][r] = 8'd0;
            for (int a = 0; a < 4; a++) xmem[f][a] = 8'd0;
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int f = 0; f < 2; f++) begin
            chk("reset_mat_ready", 32'(mat_ready[f]), 32'd0);
            chk("reset_busy", 32'(busy[f]), 32'd0);
            chk("reset_done", 32'(done[f]), 32'd0);
            chk("reset_res", res[f], 32'd0);
            chk("reset_vec_addr", 32'(vec_addr[f]), 32'd0);
            read_all(f);
        end

        // directed GF256 case
        for (int c = 0; c < COLS; c++) begin
            for (int r = 0; r < WPC * N; r++) hmat[0][c][r] = 8'd0;
            hmat[0][c][0] = 8'h01; hmat[0][c][1] = 8'h01;
            hmat[0][c][2] = 8'h02; hmat[0][c][3] = 8'h03;
            hmat[0][c][4] = 8'h05;
        end
        xmem[0][0] = 8'h02; xmem[0][1] = 8'h01; xmem[0][2] = 8'h00;
        run(0, 1'b0, 1'b0, 1'b0, -1);
        model_run(0, 1'b0);
        read_word(0, 0, 32'h0506_0303);
        read_word(0, 1, 32'h0000_000F);

        // directed P251 case, padding bytes also carry 250
        for (int c = 0; c < COLS; c++) begin
            for (int r = 0; r < WPC * N; r++) hmat[1][c][r] = 8'd250;
            xmem[1][c] = 8'd250;
        end
        run(1, 1'b0, 1'b0, 1'b0, -1);
        model_run(1, 1'b0);
        read_word(1, 0, 32'h0303_0303);
        read_word(1, 1, 32'h0000_0003);

        // add mode vs clear mode with H = 0
        for (int c = 0; c < COLS; c++) begin
            for (int r = 0; r < WPC * N; r++) hmat[0][c][r] = 8'd0;
            xmem[0][c] = 8'($urandom_range(1, 255));
        end
        host_write(0, 0, 32'h0101_0101, 1'b0);
        run(0, 1'b1, 1'b0, 1'b0, -1);
        model_run(0, 1'b1);
        read_word(0, 0, 32'h0101_0101);
        host_write(0, 0, 32'h0101_0101, 1'b0);
        run(0, 1'b0, 1'b0, 1'b0, -1);
        model_run(0, 1'b0);
        read_word(0, 0, 32'h0000_0000);

        // simultaneous write and read returns the old word
        host_write(0, 1, $urandom, 1'b1);
        read_word(0, 1, exp_word(0, 1));

        // back-pressure vs continuous, same stimulus
        for (int f = 0; f < 2; f++) begin
            rand_mat(f, 1'b0);
            run(f, 1'b0, 1'b0, 1'b0, -1);
            model_run(f, 1'b0);
            read_all(f);
            run(f, 1'b0, 1'b1, 1'b0, -1);
            model_run(f, 1'b0);
            read_all(f);
        end

        // start pulse and host write while busy are ignored
        rand_mat(0, 1'b0);
        run(0, 1'b0, 1'b0, 1'b1, -1);
        model_run(0, 1'b0);
        read_all(0);

        // reset during MAC of column 1, then a clean run
        rand_mat(0, 1'b0);
        xmem[0][0] = 8'h01;
        run(0, 1'b0, 1'b0, 1'b0, 7);
        read_all(0);
        read_all(1);
        run(0, 1'b0, 1'b0, 1'b0, -1);
        model_run(0, 1'b0);
        read_all(0);

        // randomized runs with optional preload
        for (int it = 0; it < 8; it++) begin
            int f;
            logic am;
            f = it % 2;
            am = 1'($urandom);
            rand_mat(f, 1'b1);
            if (am)
                for (int w = 0; w < WPC; w++) host_write(f, w, $urandom, 1'b0);
            run(f, am, 1'($urandom), 1'b0, -1);
            model_run(f, am);
            read_all(f);
        end

        repeat (3) @(negedge clk);
        if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
            n_chk++; n_fail++;
            $display("FAIL sb_leftover: got %0d pending, expected 0",
                     exp_q0.size() + exp_q1.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
